// File: rtl/coef_bank_seq.sv
// Runtime-writable, double-buffered biquad coefficient banks with a per-sample slot sequencer.
// Latency: first coefficient one cycle after an accepted sample_tick; six consecutive valid cycles.
// Backpressure: none; ticks arriving while busy are dropped and flagged on the sticky overrun output.
module coef_bank_seq #(
    parameter int CANT_BITS = 25,
    parameter int NUM_BANKS = 4,
    parameter int BANK_W    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic [BANK_W-1:0]    bank_sel,
    input  logic                 wr_en,
    input  logic [BANK_W-1:0]    wr_bank,
    input  logic [3:0]           wr_addr,
    input  logic [CANT_BITS-1:0] wr_data,
    input  logic                 commit_req,
    output logic [CANT_BITS-1:0] cte,
    output logic [3:0]           cte_idx,
    output logic                 cte_valid,
    output logic                 cte_last,
    output logic                 busy,
    output logic                 commit_pending,
    output logic                 overrun
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;
    localparam int         NSLOT  = 6;

    typedef logic [CANT_BITS-1:0] coef_t;

    // Storage is indexed by compact slot 0..5; external addresses 0,1,2,5,6,7 map onto it.
    coef_t shadow     [NUM_BANKS][NSLOT];
    coef_t active     [NUM_BANKS][NSLOT];
    coef_t shadow_nxt [NUM_BANKS][NSLOT];

    logic [0:0]        state;
    logic [2:0]        step;
    logic [BANK_W-1:0] bank_q;
    logic              pend_q;

    logic              wr_ok;
    logic [2:0]        wr_slot;
    logic              commit_apply;
    logic [BANK_W-1:0] rd_bank;
    logic [2:0]        rd_slot;
    coef_t             rd_data;

    // Power-on coefficient set: bank 0 holds a pass-through-like default, all other banks are zero.
    function automatic coef_t reset_val(input int b, input int s);
        coef_t v;
        v = '0;
        if (b == 0) begin
            case (s)
                0:       v = CANT_BITS'(32'h0004000);
                1:       v = CANT_BITS'(32'h0007D71);
                2:       v = CANT_BITS'(32'h1FFC287);
                3:       v = CANT_BITS'(32'h0004000);
                4:       v = CANT_BITS'(32'h1FF8000);
                5:       v = CANT_BITS'(32'h0004000);
                default: v = '0;
            endcase
        end
        return v;
    endfunction

    function automatic logic addr_legal(input logic [3:0] a);
        return (a == 4'd0) || (a == 4'd1) || (a == 4'd2) ||
               (a == 4'd5) || (a == 4'd6) || (a == 4'd7);
    endfunction

    function automatic logic [2:0] addr_to_slot(input logic [3:0] a);
        logic [2:0] s;
        case (a)
            4'd0:    s = 3'd0;
            4'd1:    s = 3'd1;
            4'd2:    s = 3'd2;
            4'd5:    s = 3'd3;
            4'd6:    s = 3'd4;
            4'd7:    s = 3'd5;
            default: s = 3'd0;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] slot_to_addr(input logic [2:0] s);
        logic [3:0] a;
        a = {1'b0, s};
        if (s > 3'd2) begin
            a = a + 4'd2;
        end
        return a;
    endfunction

    assign wr_ok          = wr_en && addr_legal(wr_addr) && (int'(wr_bank) < NUM_BANKS);
    assign wr_slot        = addr_to_slot(wr_addr);
    // Commits only land between sequences, so a running sample never sees a torn set.
    assign commit_apply   = (state == S_IDLE) && (pend_q || commit_req);
    assign commit_pending = pend_q || commit_req;

    // Next shadow contents: current shadow with this cycle's write folded in, so a same-cycle commit forwards it.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int s = 0; s < NSLOT; s++) begin
                shadow_nxt[b][s] = shadow[b][s];
                if (wr_ok && (BANK_W'(b) == wr_bank) && (3'(s) == wr_slot)) begin
                    shadow_nxt[b][s] = wr_data;
                end
            end
        end
    end

    // In IDLE the read port looks at the incoming tick's bank/slot 0; in RUN at the latched bank and current step.
    assign rd_bank = (state == S_IDLE) ? bank_sel : bank_q;
    assign rd_slot = (state == S_IDLE) ? 3'd0 : step;

    // Coefficient read mux; an out-of-range bank matches nothing and reads as zero.
    always_comb begin
        rd_data = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int s = 0; s < NSLOT; s++) begin
                if ((BANK_W'(b) == rd_bank) && (3'(s) == rd_slot)) begin
                    rd_data = commit_apply ? shadow_nxt[b][s] : active[b][s];
                end
            end
        end
    end

    // Shadow and active coefficient storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int s = 0; s < NSLOT; s++) begin
                    shadow[b][s] <= reset_val(b, s);
                    active[b][s] <= reset_val(b, s);
                end
            end
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int s = 0; s < NSLOT; s++) begin
                    shadow[b][s] <= shadow_nxt[b][s];
                    if (commit_apply) begin
                        active[b][s] <= shadow_nxt[b][s];
                    end
                end
            end
        end
    end

    // Commit request latch and sticky overrun flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q  <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (commit_apply) begin
                pend_q <= 1'b0;
            end else if (commit_req) begin
                pend_q <= 1'b1;
            end
            if (sample_tick && (state == S_RUN)) begin
                overrun <= 1'b1;
            end
        end
    end

    // Sequencer FSM with registered outputs; step counts coefficients already emitted (1..6 in RUN).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            step      <= 3'd0;
            bank_q    <= '0;
            cte       <= '0;
            cte_idx   <= 4'd0;
            cte_valid <= 1'b0;
            cte_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (sample_tick) begin
                        state     <= S_RUN;
                        step      <= 3'd1;
                        bank_q    <= bank_sel;
                        cte       <= rd_data;
                        cte_idx   <= 4'd0;
                        cte_valid <= 1'b1;
                        cte_last  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                default: begin
                    if (step == 3'd6) begin
                        state     <= S_IDLE;
                        step      <= 3'd0;
                        cte       <= '0;
                        cte_idx   <= 4'd0;
                        cte_valid <= 1'b0;
                        cte_last  <= 1'b0;
                        busy      <= 1'b0;
                    end else begin
                        step      <= step + 3'd1;
                        cte       <= rd_data;
                        cte_idx   <= slot_to_addr(step);
                        cte_valid <= 1'b1;
                        cte_last  <= (step == 3'd5);
                        busy      <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coef_bank_seq.sv
// Directed bench for coef_bank_seq with a queue scoreboard and an independent output monitor.
// Stimulus pushes the hand-computed coefficient stream; the monitor pops one entry per valid cycle.
// Built with three banks so that bank index 3 is out of range for both writes and sequences.
module tb_coef_bank_seq;

    localparam int CB = 25;
    localparam int NB = 3;
    localparam int BW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          sample_tick = 1'b0;
    logic [BW-1:0] bank_sel = '0;
    logic          wr_en = 1'b0;
    logic [BW-1:0] wr_bank = '0;
    logic [3:0]    wr_addr = 4'd0;
    logic [CB-1:0] wr_data = '0;
    logic          commit_req = 1'b0;

    logic [CB-1:0] cte;
    logic [3:0]    cte_idx;
    logic          cte_valid;
    logic          cte_last;
    logic          busy;
    logic          commit_pending;
    logic          overrun;

    coef_bank_seq #(
        .CANT_BITS (CB),
        .NUM_BANKS (NB),
        .BANK_W    (BW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .sample_tick    (sample_tick),
        .bank_sel       (bank_sel),
        .wr_en          (wr_en),
        .wr_bank        (wr_bank),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .commit_req     (commit_req),
        .cte            (cte),
        .cte_idx        (cte_idx),
        .cte_valid      (cte_valid),
        .cte_last       (cte_last),
        .busy           (busy),
        .commit_pending (commit_pending),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CB-1:0] cte;
        logic [3:0]    idx;
        logic          last;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Advance to just after the next rising edge (the input-drive point of the new cycle).
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input logic [CB-1:0] v0, input logic [CB-1:0] v1,
                            input logic [CB-1:0] v2, input logic [CB-1:0] v3,
                            input logic [CB-1:0] v4, input logic [CB-1:0] v5);
        logic [CB-1:0] v  [6];
        logic [3:0]    ix [6];
        v  = '{v0, v1, v2, v3, v4, v5};
        ix = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd7};
        for (int i = 0; i < 6; i++) begin
            sb.push_back('{cte: v[i], idx: ix[i], last: (i == 5)});
        end
    endtask

    // Tick at edge T, then walk to cycle T+7 checking busy at T+6 and T+7.
    task automatic run_seq(input logic [BW-1:0] b);
        bank_sel    = b;
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
        repeat (5) cyc();
        chk("busy_last_cycle", 32'(busy), 32'd1);
        cyc();
        chk("busy_after_seq", 32'(busy), 32'd0);
        chk("valid_after_seq", 32'(cte_valid), 32'd0);
    endtask

    task automatic wr(input logic [BW-1:0] b, input logic [3:0] a, input logic [CB-1:0] d);
        wr_en   = 1'b1;
        wr_bank = b;
        wr_addr = a;
        wr_data = d;
        cyc();
        wr_en = 1'b0;
    endtask

    // Monitor: every valid cycle must match the head of the scoreboard; idle cycles must be all-zero.
    always @(negedge clk) begin
        if (reset) begin
            if (cte_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid cte=%0h idx=%0d required=no_output", cte, cte_idx);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("cte", 32'(cte), 32'(e.cte));
                    chk("cte_idx", 32'(cte_idx), 32'(e.idx));
                    chk("cte_last", 32'(cte_last), 32'(e.last));
                    chk("busy_in_seq", 32'(busy), 32'd1);
                end
            end else begin
                chk("idle_outputs_zero", 32'({cte, cte_idx, cte_last}), 32'd0);
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) cyc();
        chk("rst_cte", 32'(cte), 32'd0);
        chk("rst_idx", 32'(cte_idx), 32'd0);
        chk("rst_flags", 32'({cte_valid, cte_last, busy, commit_pending, overrun}), 32'd0);
        reset = 1'b1;
        repeat (2) cyc();

        // Default bank 0 stream
        push_seq(25'h0004000, 25'h0007D71, 25'h1FFC287, 25'h0004000, 25'h1FF8000, 25'h0004000);
        run_seq(2'd0);

        // Shadow write is invisible until committed
        wr(2'd0, 4'd1, 25'h0001234);
        push_seq(25'h0004000, 25'h0007D71, 25'h1FFC287, 25'h0004000, 25'h1FF8000, 25'h0004000);
        run_seq(2'd0);
        commit_req = 1'b1;
        #1;
        chk("pending_on_req", 32'(commit_pending), 32'd1);
        cyc();
        commit_req = 1'b0;
        #1;
        chk("pending_cleared", 32'(commit_pending), 32'd0);
        push_seq(25'h0004000, 25'h0001234, 25'h1FFC287, 25'h0004000, 25'h1FF8000, 25'h0004000);
        run_seq(2'd0);

        // Commit during RUN waits for IDLE
        wr(2'd0, 4'd0, 25'h0002000);
        push_seq(25'h0004000, 25'h0001234, 25'h1FFC287, 25'h0004000, 25'h1FF8000, 25'h0004000);
        bank_sel    = 2'd0;
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
        repeat (2) cyc();
        commit_req = 1'b1;
        cyc();
        commit_req = 1'b0;
        repeat (2) cyc();
        chk("pending_in_run", 32'(commit_pending), 32'd1);
        cyc();
        chk("pending_after_last", 32'(commit_pending), 32'd1);
        chk("busy_t7", 32'(busy), 32'd0);
        cyc();
        chk("pending_applied", 32'(commit_pending), 32'd0);
        push_seq(25'h0002000, 25'h0001234, 25'h1FFC287, 25'h0004000, 25'h1FF8000, 25'h0004000);
        run_seq(2'd0);

        // Overrun: ticks at T+2 and T+6 ignored, tick at T+7 accepted
        chk("overrun_clear", 32'(overrun), 32'd0);
        push_seq(25'h0002000, 25'h0001234, 25'h1FFC287, 25'h0004000, 25'h1FF8000, 25'h0004000);
        bank_sel    = 2'd0;
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
        cyc();
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
        chk("overrun_set", 32'(overrun), 32'd1);
        repeat (3) cyc();
        sample_tick = 1'b1;
        cyc();
        push_seq(25'h0002000, 25'h0001234, 25'h1FFC287, 25'h0004000, 25'h1FF8000, 25'h0004000);
        cyc();
        sample_tick = 1'b0;
        repeat (5) cyc();
        chk("busy_t7_tick", 32'(busy), 32'd1);
        cyc();
        chk("overrun_sticky", 32'(overrun), 32'd1);

        // Illegal writes are ignored
        wr(2'd0, 4'd3, 25'h0AAAAAA);
        wr(2'd0, 4'd4, 25'h0555555);
        wr(2'd0, 4'd15, 25'h0333333);
        wr(2'd3, 4'd0, 25'h0123456);
        commit_req = 1'b1;
        cyc();
        commit_req = 1'b0;
        push_seq(25'h0002000, 25'h0001234, 25'h1FFC287, 25'h0004000, 25'h1FF8000, 25'h0004000);
        run_seq(2'd0);

        // Bank 2 fill, last write forwarded by a same-cycle commit
        wr(2'd2, 4'd0, 25'h0000AAA);
        wr(2'd2, 4'd1, 25'h1000001);
        wr(2'd2, 4'd2, 25'h0FFFFFF);
        wr(2'd2, 4'd5, 25'h1800000);
        wr(2'd2, 4'd6, 25'h0000001);
        commit_req = 1'b1;
        wr(2'd2, 4'd7, 25'h1234567);
        commit_req = 1'b0;
        #1;
        chk("pending_fwd", 32'(commit_pending), 32'd0);
        push_seq(25'h0000AAA, 25'h1000001, 25'h0FFFFFF, 25'h1800000, 25'h0000001, 25'h1234567);
        run_seq(2'd2);

        // Write + commit + tick in one cycle: the sequence sees the forwarded value
        wr_en       = 1'b1;
        wr_bank     = 2'd1;
        wr_addr     = 4'd0;
        wr_data     = 25'h0000111;
        commit_req  = 1'b1;
        push_seq(25'h0000111, 25'h0, 25'h0, 25'h0, 25'h0, 25'h0);
        run_seq(2'd1);
        wr_en      = 1'b0;
        commit_req = 1'b0;
        cyc();

        // Out-of-range bank: normal sequence timing, zero coefficients
        push_seq(25'h0, 25'h0, 25'h0, 25'h0, 25'h0, 25'h0);
        run_seq(2'd3);

        // Reset in the 4th cycle of a sequence
        push_seq(25'h0002000, 25'h0001234, 25'h1FFC287, 25'h0004000, 25'h1FF8000, 25'h0004000);
        void'(sb.pop_back());
        void'(sb.pop_back());
        void'(sb.pop_back());
        bank_sel    = 2'd0;
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
        repeat (3) cyc();
        reset = 1'b0;
        #1;
        chk("midrst_cte", 32'(cte), 32'd0);
        chk("midrst_flags", 32'({cte_valid, cte_last, busy, overrun}), 32'd0);
        chk("midrst_idx", 32'(cte_idx), 32'd0);
        cyc();
        reset = 1'b1;
        cyc();
        chk("overrun_after_rst", 32'(overrun), 32'd0);
        push_seq(25'h0004000, 25'h0007D71, 25'h1FFC287, 25'h0004000, 25'h1FF8000, 25'h0004000);
        run_seq(2'd0);
        push_seq(25'h0, 25'h0, 25'h0, 25'h0, 25'h0, 25'h0);
        run_seq(2'd2);

        cyc();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
